// File: rtl/fetch_pc_ctrl_pkg.sv
// rtl/fetch_pc_ctrl_pkg.sv - shared fetch definitions: state encoding, reset vector, PC step
package fetch_pc_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  // Boot vector, shared with the exception logic.
  localparam logic [31:0] CPU_RESET_PC = 32'hbfc00000;

  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_ctrl_resp_buf.sv
// rtl/fetch_pc_ctrl_resp_buf.sv - holds one fetched {instruction, pc} while decode is stalled
module fetch_pc_ctrl_resp_buf
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  input  logic [WIDTH-1:0] i_pc,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [WIDTH-1:0] o_pc
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_pc;

  // A load always wins: a new response can only arrive when the buffer is empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_pc    <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_pc    <= i_pc;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - fetch sequencer: owns the PC, drives the split-handshake
// instruction bus and merges sequential, branch and exception redirects.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(CPU_RESET_PC)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             stall_i,
  input  logic             br_redirect_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             exc_redirect_i,
  input  logic [WIDTH-1:0] exc_target_i,
  output logic             inst_req,
  output logic [WIDTH-1:0] inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [WIDTH-1:0] inst_rdata,
  output logic             instr_valid_o,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] instr_pc_o,
  output logic             fetch_busy_o,
  output logic [WIDTH-1:0] pc_o
);

  fetch_state_e     r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_req_pc;
  logic             r_discard;

  logic             w_redirect;
  logic [WIDTH-1:0] w_target;
  logic             w_deliver_now;
  logic             w_buf_load;
  logic             w_buf_clear;
  logic             w_buf_valid;
  logic [WIDTH-1:0] w_buf_data;
  logic [WIDTH-1:0] w_buf_pc;
  logic             w_hold_out;

  assign w_redirect = br_redirect_i | exc_redirect_i;
  assign w_target   = exc_redirect_i ? exc_target_i : br_target_i;

  // A live response either goes straight to decode or parks in the buffer.
  assign w_deliver_now = (r_state == ST_WAIT) & inst_data_ok & ~r_discard & ~stall_i & ~w_redirect;
  assign w_buf_load    = (r_state == ST_WAIT) & inst_data_ok & ~r_discard &  stall_i & ~w_redirect;
  assign w_buf_clear   = (r_state == ST_HOLD) & (w_redirect | ~stall_i);
  assign w_hold_out    = (r_state == ST_HOLD) & w_buf_valid & ~w_redirect;

  fetch_pc_ctrl_resp_buf #(
    .WIDTH(WIDTH)
  ) u_resp_buf (
    .clk     (clk),
    .resetn  (resetn),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_data  (inst_rdata),
    .i_pc    (r_req_pc),
    .o_valid (w_buf_valid),
    .o_data  (w_buf_data),
    .o_pc    (w_buf_pc)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_BOOT;
      r_pc      <= RESET_PC;
      r_req_pc  <= '0;
      r_discard <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          if (w_redirect) r_pc <= w_target;
          r_state <= ST_REQ;
        end
        ST_REQ: begin
          if (inst_addr_ok) begin
            r_req_pc <= r_pc;
            r_state  <= ST_WAIT;
            // The old address is already on its way; its response must be dropped.
            if (w_redirect) begin
              r_discard <= 1'b1;
              r_pc      <= w_target;
            end
          end else if (w_redirect) begin
            r_pc <= w_target;
          end
        end
        ST_WAIT: begin
          if (inst_data_ok) begin
            r_state   <= ST_REQ;
            r_discard <= 1'b0;
            if (w_redirect) begin
              r_pc <= w_target;
            end else if (!r_discard) begin
              if (!stall_i) r_pc    <= r_req_pc + WIDTH'(PC_STEP);
              else          r_state <= ST_HOLD;
            end
          end else if (w_redirect) begin
            r_discard <= 1'b1;
            r_pc      <= w_target;
          end
        end
        ST_HOLD: begin
          if (w_redirect) begin
            r_pc    <= w_target;
            r_state <= ST_REQ;
          end else if (!stall_i) begin
            r_pc    <= w_buf_pc + WIDTH'(PC_STEP);
            r_state <= ST_REQ;
          end
        end
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  always_comb begin
    instr_valid_o = 1'b0;
    instr_o       = '0;
    instr_pc_o    = '0;
    if (w_deliver_now) begin
      instr_valid_o = 1'b1;
      instr_o       = inst_rdata;
      instr_pc_o    = r_req_pc;
    end else if (w_hold_out) begin
      instr_valid_o = 1'b1;
      instr_o       = w_buf_data;
      instr_pc_o    = w_buf_pc;
    end
  end

  assign inst_req     = (r_state == ST_REQ);
  assign inst_addr    = r_pc;
  assign pc_o         = r_pc;
  assign fetch_busy_o = ~instr_valid_o;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb/tb_fetch_pc_ctrl.sv - randomized bench for fetch_pc_ctrl against a transaction-level fetch model
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RST_PC = 32'hbfc00000;

  logic        clk;
  logic        resetn;
  logic        stall_i;
  logic        br_redirect_i;
  logic [31:0] br_target_i;
  logic        exc_redirect_i;
  logic [31:0] exc_target_i;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        fetch_busy_o;
  logic [31:0] pc_o;

  fetch_pc_ctrl #(
    .WIDTH    (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .stall_i        (stall_i),
    .br_redirect_i  (br_redirect_i),
    .br_target_i    (br_target_i),
    .exc_redirect_i (exc_redirect_i),
    .exc_target_i   (exc_target_i),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .instr_valid_o  (instr_valid_o),
    .instr_o        (instr_o),
    .instr_pc_o     (instr_pc_o),
    .fetch_busy_o   (fetch_busy_o),
    .pc_o           (pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: next architectural PC, one undelivered instruction, one bus fetch.
  logic [31:0] exp_pc;
  logic        pending;
  logic        bus_busy;
  logic        bus_stale;
  logic [31:0] bus_addr;
  int          bus_cnt;
  int          ack_pct;
  int          lat_lo;
  int          lat_hi;
  logic        arm_ack;
  logic [31:0] arm_tgt;
  logic        saw_valid;
  logic [31:0] saw_pc;
  int          n_dlv;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ (a * 32'd2654435761) ^ 32'h3c1d0000;
  endfunction

  task automatic cycle(input logic stall, input logic br, input logic [31:0] bt,
                       input logic exc, input logic [31:0] et);
    logic red, fresh, ev, exp_req;
    logic [31:0] tgt;
    @(posedge clk); #1;
    stall_i        = stall;
    br_redirect_i  = br;
    br_target_i    = bt;
    exc_redirect_i = exc;
    exc_target_i   = et;
    inst_addr_ok   = inst_req && !bus_busy && ($urandom_range(99) < ack_pct);
    inst_data_ok   = bus_busy && (bus_cnt == 0);
    inst_rdata     = inst_data_ok ? mem_word(bus_addr) : $urandom;
    if (arm_ack && inst_addr_ok) begin
      br_redirect_i  = 1'b1;
      br_target_i    = arm_tgt;
      exc_redirect_i = 1'b0;
      arm_ack        = 1'b0;
    end
    @(negedge clk);
    red     = br_redirect_i | exc_redirect_i;
    tgt     = exc_redirect_i ? exc_target_i : br_target_i;
    fresh   = inst_data_ok && !bus_stale;
    ev      = !red && (pending || (fresh && !stall_i));
    exp_req = !bus_busy && !pending;
    check_eq("valid", instr_valid_o, ev);
    check_eq("busy", fetch_busy_o, !ev);
    check_eq("req", inst_req, exp_req);
    check_eq("pc", pc_o, exp_pc);
    if (exp_req) check_eq("addr", inst_addr, exp_pc);
    if (ev) begin
      check_eq("instr_pc", instr_pc_o, exp_pc);
      check_eq("instr", instr_o, mem_word(exp_pc));
    end
    saw_valid = instr_valid_o;
    saw_pc    = instr_pc_o;
    if (ev && !stall_i) n_dlv++;
    if (inst_data_ok) bus_busy = 1'b0;
    else if (bus_busy) bus_cnt--;
    if (inst_addr_ok) begin
      bus_busy  = 1'b1;
      bus_stale = 1'b0;
      bus_addr  = inst_addr;
      bus_cnt   = $urandom_range(lat_hi, lat_lo);
    end
    if (red && bus_busy) bus_stale = 1'b1;
    if (red) pending = 1'b0;
    else if (ev && !stall_i) pending = 1'b0;
    else if (fresh && stall_i) pending = 1'b1;
    if (red) exp_pc = tgt;
    else if (ev && !stall_i) exp_pc = exp_pc + 32'd4;
  endtask

  task automatic run_until_dlv(output logic [31:0] pc);
    int n;
    n = 0;
    do begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      n++;
    end while (!saw_valid && n < 100);
    check_eq("dlv_timeout", saw_valid, 1'b1);
    pc = saw_pc;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check_eq("boot_req", inst_req, 1'b0);
    check_eq("boot_valid", instr_valid_o, 1'b0);
  endtask

  initial begin
    logic [31:0] pc;
    int held, n;
    resetn = 1'b0; stall_i = 1'b0; br_redirect_i = 1'b0; br_target_i = '0;
    exc_redirect_i = 1'b0; exc_target_i = '0; inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0; inst_rdata = '0;
    exp_pc = RST_PC; pending = 1'b0; bus_busy = 1'b0; bus_stale = 1'b0;
    bus_addr = '0; bus_cnt = 0; ack_pct = 100; lat_lo = 1; lat_hi = 1;
    arm_ack = 1'b0; arm_tgt = '0; saw_valid = 1'b0; saw_pc = '0; n_dlv = 0;

    #23;
    check_eq("rst_pc", pc_o, RST_PC);
    check_eq("rst_req", inst_req, 1'b0);
    check_eq("rst_valid", instr_valid_o, 1'b0);
    check_eq("rst_instr", instr_o, 32'h0);
    check_eq("rst_instr_pc", instr_pc_o, 32'h0);
    check_eq("rst_busy", fetch_busy_o, 1'b1);
    release_reset();

    run_until_dlv(pc); check_eq("first_pc", pc, 32'hbfc00000);
    run_until_dlv(pc); check_eq("second_pc", pc, 32'hbfc00004);

    n = 0; saw_valid = 1'b0;
    while (!saw_valid && n < 20) begin cycle(1'b1, 1'b0, 0, 1'b0, 0); n++; end
    held = saw_valid ? 1 : 0;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 0, 1'b0, 0);
      if (saw_valid && saw_pc == 32'hbfc00008) held++;
    end
    check_eq("stall_held", held, 3);
    cycle(1'b0, 1'b0, 0, 1'b0, 0);
    check_eq("stall_consume", saw_valid, 1'b1);
    run_until_dlv(pc); check_eq("after_stall_pc", pc, 32'hbfc0000c);

    lat_lo = 2; lat_hi = 2; n = 0;
    do begin cycle(1'b0, 1'b0, 0, 1'b0, 0); n++; end while (!(bus_busy && bus_cnt > 0) && n < 50);
    cycle(1'b0, 1'b1, 32'hbfc00100, 1'b0, 0);
    run_until_dlv(pc); check_eq("br_wait_pc", pc, 32'hbfc00100);

    cycle(1'b0, 1'b1, 32'hbfc00100, 1'b1, 32'hbfc00380);
    run_until_dlv(pc); check_eq("exc_prio_pc", pc, 32'hbfc00380);

    arm_ack = 1'b1; arm_tgt = 32'hbfc00200;
    run_until_dlv(pc); check_eq("ack_redir_pc", pc, 32'hbfc00200);
    check_eq("ack_redir_fired", arm_ack, 1'b0);

    cycle(1'b0, 1'b1, 32'hfffffff8, 1'b0, 0);
    run_until_dlv(pc); check_eq("wrap_pc0", pc, 32'hfffffff8);
    run_until_dlv(pc); check_eq("wrap_pc1", pc, 32'hfffffffc);
    run_until_dlv(pc); check_eq("wrap_pc2", pc, 32'h00000000);

    n = 0;
    while (!pending && n < 50) begin cycle(1'b1, 1'b0, 0, 1'b0, 0); n++; end
    check_eq("hold_reached", pending, 1'b1);
    @(posedge clk); #1;
    stall_i = 1'b1; br_redirect_i = 1'b0; exc_redirect_i = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    #1 check_eq("hold_valid", instr_valid_o, 1'b1);
    resetn = 1'b0;
    #1;
    check_eq("mid_rst_valid", instr_valid_o, 1'b0);
    check_eq("mid_rst_pc", pc_o, RST_PC);
    check_eq("mid_rst_req", inst_req, 1'b0);
    exp_pc = RST_PC; pending = 1'b0; bus_busy = 1'b0; bus_stale = 1'b0;
    stall_i = 1'b0;
    release_reset();
    run_until_dlv(pc); check_eq("post_rst_pc", pc, RST_PC);

    ack_pct = 60; lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t1, t2;
      t1 = ($urandom_range(3) == 0) ? 32'hfffffff8 : ({$urandom} & 32'hfffffffc);
      t2 = ($urandom_range(1) == 0) ? 32'hbfc00380 : ({$urandom} & 32'hfffffffc);
      cycle($urandom_range(99) < 30, $urandom_range(99) < 8, t1, $urandom_range(99) < 4, t2);
    end
    check_eq("progress", n_dlv > 200, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
